// File: rtl/activation_stream_pkg.sv
// Shared types for the activation_stream datapath: activation modes, constant
// bundles and the stream beat layout.
package activation_stream_pkg;

  localparam int unsigned CONST_W    = 16;
  localparam int unsigned RQ_W       = 8;
  localparam int unsigned BEAT_LANES = 16;
  localparam int unsigned LANE_W     = 8;
  // Wide enough for x*(erf+one)*mult at full precision
  localparam int unsigned WIDE       = 64;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_GELU     = 2'd2
  } activation_e;

  typedef struct packed {
    logic signed [CONST_W-1:0] one;
    logic signed [CONST_W-1:0] b;
    logic signed [CONST_W-1:0] c;
  } gelu_const_t;

  typedef struct packed {
    logic        [RQ_W-1:0]    mult;
    logic        [RQ_W-1:0]    shift;
    logic signed [CONST_W-1:0] add;
  } requant_const_t;

  typedef struct packed {
    logic [BEAT_LANES*LANE_W-1:0] data;
    activation_e                  act;
  } beat_t;

  // Code 3 is not a mode of its own and behaves as IDENTITY.
  function automatic activation_e decode_act(input logic [1:0] code);
    case (code)
      2'd1:    return ACT_RELU;
      2'd2:    return ACT_GELU;
      default: return ACT_IDENTITY;
    endcase
  endfunction

endpackage

// File: rtl/activation_stream_lane.sv
// One lane of activation_stream: S1 holds x and the GELU product, S2 holds the
// requantised/clipped or bypassed result.
module activation_lane
  import activation_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s1_load,
  input  logic                     s2_load,
  input  logic signed [DATA_W-1:0] x,
  input  activation_e              s1_act,
  input  gelu_const_t              gelu,
  input  requant_const_t           rq,
  output logic signed [DATA_W-1:0] y,
  output logic                     clip
);

  localparam logic signed [WIDE-1:0] Y_MAX =
    $signed({{(WIDE-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [WIDE-1:0] Y_MIN =
    $signed({{(WIDE-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  logic signed [WIDE-1:0]   xw, ax, lim, t, erf, p_next;
  logic signed [DATA_W-1:0] s1_x;
  logic signed [WIDE-1:0]   s1_p;
  logic signed [WIDE-1:0]   mult_w, round, q;
  logic                     clip_hi, clip_lo;
  logic signed [DATA_W-1:0] y_next;

  always_comb begin
    xw     = WIDE'(x);
    ax     = x[DATA_W-1] ? -xw : xw;
    lim    = -WIDE'($signed(gelu.b));
    t      = ((ax < lim) ? ax : lim) + WIDE'($signed(gelu.b));
    erf    = WIDE'($signed(gelu.c)) - t * t;
    if (x[DATA_W-1]) erf = -erf;
    p_next = xw * (erf + WIDE'($signed(gelu.one)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_x <= '0;
      s1_p <= '0;
    end else if (s1_load) begin
      s1_x <= x;
      s1_p <= p_next;
    end
  end

  always_comb begin
    mult_w  = $signed(WIDE'(rq.mult));
    round   = (rq.shift == '0) ? '0 : ($signed(WIDE'(1)) <<< (rq.shift - RQ_W'(1)));
    q       = ((s1_p * mult_w + round) >>> rq.shift) + WIDE'($signed(rq.add));
    clip_hi = q > Y_MAX;
    clip_lo = q < Y_MIN;
    clip    = 1'b0;
    y_next  = s1_x;
    case (s1_act)
      ACT_GELU: begin
        clip   = clip_hi | clip_lo;
        y_next = clip_hi ? Y_MAX[DATA_W-1:0] :
                 clip_lo ? Y_MIN[DATA_W-1:0] : q[DATA_W-1:0];
      end
      ACT_RELU: y_next = s1_x[DATA_W-1] ? '0 : s1_x;
      default:  y_next = s1_x;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) y <= '0;
    else if (s2_load) y <= y_next;
  end

endmodule

// File: rtl/activation_stream.sv
// Two-stage streaming activation (IDENTITY/RELU/GELU+requant) with global stall.
// Optional clipped-lane counter enabled by ACTIVATION_SAT_CNT_EN.
module activation_stream
  import activation_stream_pkg::*;
#(
  parameter int unsigned N_LANES = 16,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [N_LANES*DATA_W-1:0]   in_data_i,
  input  logic [1:0]                  in_act_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [N_LANES*DATA_W-1:0]   out_data_o,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [CONST_W-1:0]          cfg_one_i,
  input  logic [CONST_W-1:0]          cfg_b_i,
  input  logic [CONST_W-1:0]          cfg_c_i,
  input  logic [CONST_W-1:0]          cfg_add_i,
  input  logic [RQ_W-1:0]             cfg_mult_i,
  input  logic [RQ_W-1:0]             cfg_shift_i,
  output logic                        idle_o,
  output logic [31:0]                 sat_cnt_o
);

  logic           en, accept, s2_load, cfg_fire;
  logic           s1_valid, s2_valid;
  activation_e    s1_act;
  gelu_const_t    gelu_q;
  requant_const_t rq_q;
  logic [N_LANES-1:0] clip;

  // Whole pipeline advances together; S1 may carry a bubble into S2.
  assign en          = ~s2_valid | out_ready_i;
  assign in_ready_o  = en;
  assign accept      = in_valid_i & en;
  assign s2_load     = en & s1_valid;
  assign idle_o      = ~s1_valid & ~s2_valid;
  assign cfg_ready_o = idle_o & ~in_valid_i;
  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign out_valid_o = s2_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_act   <= ACT_IDENTITY;
    end else if (en) begin
      s1_valid <= in_valid_i;
      s2_valid <= s1_valid;
      if (in_valid_i) s1_act <= decode_act(in_act_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gelu_q <= '0;
      rq_q   <= '0;
    end else if (cfg_fire) begin
      gelu_q <= '{one: cfg_one_i, b: cfg_b_i, c: cfg_c_i};
      rq_q   <= '{mult: cfg_mult_i, shift: cfg_shift_i, add: cfg_add_i};
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    activation_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .s1_load (accept),
      .s2_load (s2_load),
      .x       (in_data_i[i*DATA_W +: DATA_W]),
      .s1_act  (s1_act),
      .gelu    (gelu_q),
      .rq      (rq_q),
      .y       (out_data_o[i*DATA_W +: DATA_W]),
      .clip    (clip[i])
    );
  end

`ifdef ACTIVATION_SAT_CNT_EN
  logic [31:0] sat_cnt, clip_sum;
  logic [32:0] sat_sum;

  always_comb begin
    clip_sum = '0;
    for (int unsigned i = 0; i < N_LANES; i++) clip_sum = clip_sum + 32'(clip[i]);
    sat_sum = {1'b0, sat_cnt} + {1'b0, clip_sum};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         sat_cnt <= '0;
    else if (cfg_fire) sat_cnt <= '0;
    else if (s2_load)  sat_cnt <= sat_sum[32] ? '1 : sat_sum[31:0];
  end

  assign sat_cnt_o = sat_cnt;
`else
  logic unused_clip;
  assign unused_clip = ^clip;
  assign sat_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_activation_stream.sv
// Directed self-checking bench for activation_stream.
module tb_activation_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [1:0]   in_act;
  logic         cfg_valid, cfg_ready, idle;
  logic [15:0]  cfg_one, cfg_b, cfg_c, cfg_add;
  logic [7:0]   cfg_mult, cfg_shift;
  logic [31:0]  sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  activation_stream #(.N_LANES(16), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_act_i    (in_act),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_one_i   (cfg_one),
    .cfg_b_i     (cfg_b),
    .cfg_c_i     (cfg_c),
    .cfg_add_i   (cfg_add),
    .cfg_mult_i  (cfg_mult),
    .cfg_shift_i (cfg_shift),
    .idle_o      (idle),
    .sat_cnt_o   (sat_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] pair(input logic [7:0] lo, input logic [7:0] hi);
    return {8{hi, lo}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]   gx [6];
  logic [7:0]   gy [6];
  logic [127:0] held;
  int           sent, rcv;

  initial begin
    gx = '{8'd4, 8'hFC, 8'd0, 8'd2, 8'd127, 8'h80};
    gy = '{8'd64, 8'd0, 8'd0, 8'd28, 8'd127, 8'd0};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_act = 2'd0; out_ready = 1'b1;
    cfg_valid = 1'b0; cfg_one = '0; cfg_b = '0; cfg_c = '0; cfg_add = '0;
    cfg_mult = '0; cfg_shift = '0;

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_sat_cnt", sat_cnt, 0);
    in_valid = 1'b1; #1;
    chk("rst_cfg_ready_inv", cfg_ready, 0);
    in_valid = 1'b0;
    step(); rst = 1'b0; step();

    // load test constants
    cfg_valid = 1'b1; cfg_one = 16'd16; cfg_b = 16'hFFFC; cfg_c = 16'd16;
    cfg_mult = 8'd1; cfg_shift = 8'd1; cfg_add = 16'd0;
    #1; chk("cfg_ready_idle", cfg_ready, 1);
    step(); cfg_valid = 1'b0;

    // GELU beats back-to-back, 2-cycle latency
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin in_valid = 1'b1; in_act = 2'd2; in_data = rep(gx[i]); end
      else in_valid = 1'b0;
      step();
      if (i == 0) chk("gelu_latency", out_valid, 0);
      else if (i <= 6) begin
        chk("gelu_valid", out_valid, 1);
        chk($sformatf("gelu_x%0d", i - 1), out_data, rep(gy[i-1]));
      end else begin
        chk("gelu_drain_valid", out_valid, 0);
        chk("gelu_drain_idle", idle, 1);
      end
    end
`ifdef ACTIVATION_SAT_CNT_EN
    chk("sat_after_gelu", sat_cnt, 16);
`else
    chk("sat_tied_zero", sat_cnt, 0);
`endif

    // RELU, IDENTITY, code 3 back-to-back
    in_valid = 1'b1; in_act = 2'd1; in_data = pair(8'hFB, 8'd7);
    step();
    in_act = 2'd0;
    step();
    chk("relu_valid", out_valid, 1);
    chk("relu_data", out_data, pair(8'd0, 8'd7));
    in_act = 2'd3; in_data = pair(8'h80, 8'h7F);
    step();
    chk("ident_valid", out_valid, 1);
    chk("ident_data", out_data, pair(8'hFB, 8'd7));
    in_valid = 1'b0;
    step();
    chk("act3_valid", out_valid, 1);
    chk("act3_data", out_data, pair(8'h80, 8'h7F));
    step();
    chk("mix_drain", out_valid, 0);

    // 10 beats with a 5-cycle downstream stall
    sent = 0; rcv = 0; held = '0;
    for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (sent < 10) begin in_valid = 1'b1; in_act = 2'd0; in_data = rep(8'(20 + sent)); end
      else in_valid = 1'b0;
      #1;
      if (cyc >= 4 && cyc <= 8) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (cyc == 4) held = out_data;
        else chk("stall_stable", out_data, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stall_beat%0d", rcv), out_data, rep(8'(20 + rcv)));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    chk("stall_rcv_count", rcv, 10);
    chk("stall_sent_count", sent, 10);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("stall_idle", idle, 1);

    // config request while a beat is in flight
    in_valid = 1'b1; in_act = 2'd2; in_data = rep(8'd4);
    cfg_valid = 1'b1; cfg_mult = 8'd2;
    #1; chk("cfg_blocked_by_data", cfg_ready, 0);
    step();
    in_valid = 1'b0; #1;
    chk("cfg_blocked_s1", cfg_ready, 0);
    step();
    chk("cfg_old_valid", out_valid, 1);
    chk("cfg_old_data", out_data, rep(8'd64));
    chk("cfg_blocked_s2", cfg_ready, 0);
    step();
    chk("cfg_idle", idle, 1);
    chk("cfg_ready_open", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("sat_cleared", sat_cnt, 0);
    in_valid = 1'b1; in_act = 2'd2; in_data = rep(8'd4);
    step();
    in_valid = 1'b0;
    step();
    chk("cfg_new_valid", out_valid, 1);
    chk("cfg_new_clip", out_data, rep(8'd127));
`ifdef ACTIVATION_SAT_CNT_EN
    chk("sat_after_clip", sat_cnt, 16);
`else
    chk("sat_tied_zero2", sat_cnt, 0);
`endif
    step();

    // reset with two beats in flight
    in_valid = 1'b1; in_act = 2'd0; in_data = rep(8'h33);
    step();
    in_data = rep(8'h44);
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, rep(8'h33));
    rst = 1'b1; #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_idle", idle, 1);
    chk("rst_mid_sat", sat_cnt, 0);
    step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_ghost", out_valid, 0);
    end

    // constants back at zero: GELU of 4 collapses to 0
    in_valid = 1'b1; in_act = 2'd2; in_data = rep(8'd4);
    step();
    in_valid = 1'b0;
    step();
    chk("zero_const_valid", out_valid, 1);
    chk("zero_const_data", out_data, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
